// File: rtl/rom_sequencer.sv
// Purpose : read controller for a 1-cycle registered lookup ROM; steps the
//           address at a programmable rate with run/stop, single-step, load,
//           and wrap or bounce sequencing.
// Latency : o_valid is high one cycle after each o_rom_en cycle, in the
//           cycle the ROM's DATA_OUT holds that word.
// Backpressure: none; reads are paced only by the prescaler (i_div) or by
//           i_step, and downstream must capture on o_valid.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      IDLE -> RUN (samples i_dir)
//   i_stop       RUN -> IDLE
//   i_step       one read while IDLE
//   i_load       load address from i_load_addr (samples i_dir)
//   i_load_addr  load value
//   i_dir        1 = up, 0 = down
//   i_mode       0 = wrap, 1 = bounce (live)
//   i_div        read period minus 1 (live)
//   o_rom_addr   to ROM ADDR
//   o_rom_en     to ROM EN, one-cycle pulse per read
//   o_valid      ROM DATA_OUT holds the word for the previous read
//   o_running    high while in RUN
//   o_wrap       pulse with the o_valid of a rollover/reversal read
module rom_sequencer #(
  parameter int ADDR_BITS = 8,
  parameter int DIV_BITS  = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_step,
  input  logic                 i_load,
  input  logic [ADDR_BITS-1:0] i_load_addr,
  input  logic                 i_dir,
  input  logic                 i_mode,
  input  logic [DIV_BITS-1:0]  i_div,
  output logic [ADDR_BITS-1:0] o_rom_addr,
  output logic                 o_rom_en,
  output logic                 o_valid,
  output logic                 o_running,
  output logic                 o_wrap
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [DIV_BITS-1:0]  DIV_ONE  = DIV_BITS'(1);

  state_t               r_state;
  logic [DIV_BITS-1:0]  r_pcnt;
  logic                 r_dir;
  logic [ADDR_BITS-1:0] r_rom_addr;
  logic                 r_rom_en;
  logic                 r_valid;
  logic                 r_wrap;

  logic [ADDR_BITS-1:0] w_next_addr;
  logic                 w_at_end;
  logic                 w_flip;
  logic                 w_pcnt_hit;

  // Address step for the read currently on the bus. Being at the end we are
  // moving towards is a rollover in wrap mode and a reversal in bounce mode.
  always_comb begin
    w_at_end = r_dir ? (r_rom_addr == ADDR_MAX) : (r_rom_addr == '0);
    w_flip   = w_at_end & i_mode;
    if (w_flip) begin
      w_next_addr = r_dir ? (ADDR_MAX - ADDR_ONE) : ADDR_ONE;
    end else begin
      w_next_addr = r_dir ? (r_rom_addr + ADDR_ONE) : (r_rom_addr - ADDR_ONE);
    end
  end

  // >= rather than == so that lowering i_div below the current count fires
  // at once instead of running the counter all the way round.
  assign w_pcnt_hit = (r_pcnt >= i_div);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_pcnt     <= '0;
      r_dir      <= 1'b1;
      r_rom_addr <= '0;
      r_rom_en   <= 1'b0;
      r_valid    <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      // Completion of the read issued last cycle happens regardless of the
      // command below; the command assignments further down take precedence
      // over the address/direction update (LOAD, START re-sample).
      r_valid <= r_rom_en;
      r_wrap  <= r_rom_en & w_at_end;
      if (r_rom_en) begin
        r_rom_addr <= w_next_addr;
        if (w_flip) r_dir <= ~r_dir;
      end

      if (i_load) begin
        r_rom_addr <= i_load_addr;
        r_dir      <= i_dir;
        r_pcnt     <= '0;
        r_rom_en   <= 1'b0;
      end else if (i_stop) begin
        r_state  <= S_IDLE;
        r_rom_en <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state  <= S_RUN;
              r_pcnt   <= '0;
              r_dir    <= i_dir;
              r_rom_en <= 1'b0;
            end else begin
              r_rom_en <= i_step;
            end
          end
          S_RUN: begin
            if (w_pcnt_hit) begin
              r_pcnt   <= '0;
              r_rom_en <= 1'b1;
            end else begin
              r_pcnt   <= r_pcnt + DIV_ONE;
              r_rom_en <= 1'b0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_rom_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_rom_en   = r_rom_en;
  assign o_valid    = r_valid;
  assign o_running  = (r_state == S_RUN);
  assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: directed scenarios plus a randomized run, all
// compared against a cycle-level reference model built from integer math.
module tb_rom_sequencer;

  localparam int AW   = 8;
  localparam int DW   = 24;
  localparam int MAXA = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, step = 1'b0, load = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic          dir = 1'b1, mode = 1'b0;
  logic [DW-1:0] div = '0;
  logic [AW-1:0] o_rom_addr;
  logic          o_rom_en, o_valid, o_running, o_wrap;

  rom_sequencer #(.ADDR_BITS(AW), .DIV_BITS(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_step(step), .i_load(load), .i_load_addr(load_addr), .i_dir(dir),
    .i_mode(mode), .i_div(div), .o_rom_addr(o_rom_addr), .o_rom_en(o_rom_en),
    .o_valid(o_valid), .o_running(o_running), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  wire [AW+3:0] obs = {o_rom_addr, o_rom_en, o_valid, o_running, o_wrap};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers)
  int m_addr = 0, m_pcnt = 0;
  bit m_run = 0, m_up = 1, m_en = 0, m_valid = 0, m_wrap = 0;

  function automatic logic [AW+3:0] model_vec();
    logic [AW-1:0] a;
    a = AW'(m_addr);
    return {a, m_en, m_valid, m_run, m_wrap};
  endfunction

  // One clock edge of the sequencer, described as: "a pending read finishes,
  // then the highest-priority command decides what is issued next".
  task automatic model_update();
    int  nxt;
    bit  rolled, reverse;
    if (!rst_n) begin
      m_addr = 0; m_pcnt = 0; m_run = 0; m_up = 1;
      m_en = 0; m_valid = 0; m_wrap = 0;
      return;
    end
    rolled  = 0;
    reverse = 0;
    nxt     = m_addr;
    if (m_en) begin
      if (m_up) begin
        rolled = (m_addr == MAXA);
        nxt    = (rolled && mode) ? MAXA - 1 : (m_addr + 1) % (MAXA + 1);
      end else begin
        rolled = (m_addr == 0);
        nxt    = (rolled && mode) ? 1 : (m_addr + MAXA) % (MAXA + 1);
      end
      reverse = rolled && mode;
    end
    m_valid = m_en;
    m_wrap  = rolled;
    m_addr  = nxt;
    if (reverse) m_up = !m_up;

    if (load) begin
      m_addr = int'(load_addr); m_up = dir; m_pcnt = 0; m_en = 0;
    end else if (stop) begin
      m_run = 0; m_en = 0;
    end else if (start && !m_run) begin
      m_run = 1; m_pcnt = 0; m_up = dir; m_en = 0;
    end else if (m_run) begin
      m_en   = (m_pcnt >= int'(div));
      m_pcnt = m_en ? 0 : m_pcnt + 1;
    end else begin
      m_en = step;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_step();
    clk_step();
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %h exp 0", obs);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL reset_model got %h exp %h", obs, model_vec());
    end
    rst_n = 1'b1;
    clk_step();
  endtask

  task automatic test_run_div3();
    int  k = 0;
    bit  prev_en;
    div = 3; dir = 1'b1; mode = 1'b0; start = 1'b1;
    clk_step();
    start = 1'b0;
    prev_en = o_rom_en;
    n_cmp++;
    if (o_running !== 1'b1) begin
      n_bad++; $display("FAIL div3_running got %b exp 1", o_running);
    end
    for (int c = 1; c <= 16; c++) begin
      clk_step();
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++; $display("FAIL div3_model c=%0d got %h exp %h", c, obs, model_vec());
      end
      n_cmp++;
      if (o_rom_en !== ((c % 4) == 0)) begin
        n_bad++; $display("FAIL div3_en c=%0d got %b exp %b", c, o_rom_en, (c % 4) == 0);
      end
      if (o_rom_en) begin
        n_cmp++;
        if (o_rom_addr !== k[AW-1:0]) begin
          n_bad++; $display("FAIL div3_addr got %h exp %h", o_rom_addr, k[AW-1:0]);
        end
        k++;
      end
      n_cmp++;
      if (o_valid !== prev_en) begin
        n_bad++; $display("FAIL div3_valid c=%0d got %b exp %b", c, o_valid, prev_en);
      end
      prev_en = o_rom_en;
    end
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
    clk_step();
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL div3_stop got %h exp %h", obs, model_vec());
    end
  endtask

  // Shared by the wrap and bounce scenarios: load FE going up, run at DIV=0
  // and collect the first four issued addresses and the WRAP pulses.
  task automatic test_sequence(input bit bounce, input string nm,
                               input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                               input logic [AW-1:0] e2, input logic [AW-1:0] e3);
    logic [AW-1:0] iss[4];
    logic [AW-1:0] exp_a[4];
    logic [AW-1:0] last_iss = '0;
    int nq = 0, nwrap = 0;
    exp_a = '{e0, e1, e2, e3};
    mode = bounce; load = 1'b1; load_addr = 8'hFE; dir = 1'b1; div = 0;
    clk_step();
    load = 1'b0; start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      clk_step();
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++; $display("FAIL %s_model got %h exp %h", nm, obs, model_vec());
      end
      n_cmp++;
      if (o_running !== 1'b1) begin
        n_bad++; $display("FAIL %s_running got %b exp 1", nm, o_running);
      end
      if (o_valid) begin
        n_cmp++;
        if (o_wrap !== (last_iss == 8'hFF)) begin
          n_bad++; $display("FAIL %s_wrap after %h got %b", nm, last_iss, o_wrap);
        end
      end
      if (o_wrap) nwrap++;
      if (o_rom_en) begin
        last_iss = o_rom_addr;
        if (nq < 4) begin
          iss[nq] = o_rom_addr;
          nq++;
        end
      end
    end
    n_cmp++;
    if (nq !== 4) begin
      n_bad++; $display("FAIL %s_issue_count got %0d exp 4", nm, nq);
    end
    for (int i = 0; i < nq; i++) begin
      n_cmp++;
      if (iss[i] !== exp_a[i]) begin
        n_bad++; $display("FAIL %s_issue%0d got %h exp %h", nm, i, iss[i], exp_a[i]);
      end
    end
    n_cmp++;
    if (nwrap !== 1) begin
      n_bad++; $display("FAIL %s_wrap_count got %0d exp 1", nm, nwrap);
    end
    stop = 1'b1;
    clk_step();
    stop = 1'b0; mode = 1'b0;
    clk_step();
  endtask

  task automatic test_step();
    int ne = 0;
    load = 1'b1; load_addr = 8'h10; dir = 1'b1;
    clk_step();
    load = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      for (int c = 0; c < 4; c++) begin
        clk_step();
        step = 1'b0;
        n_cmp++;
        if (obs !== model_vec()) begin
          n_bad++; $display("FAIL step_model got %h exp %h", obs, model_vec());
        end
        n_cmp++;
        if (o_running !== 1'b0) begin
          n_bad++; $display("FAIL step_running got %b exp 0", o_running);
        end
        if (o_rom_en) begin
          n_cmp++;
          if (o_rom_addr !== AW'(8'h10 + ne)) begin
            n_bad++; $display("FAIL step_addr got %h exp %h", o_rom_addr, AW'(8'h10 + ne));
          end
          ne++;
        end
      end
    end
    n_cmp++;
    if (ne !== 3) begin
      n_bad++; $display("FAIL step_count got %0d exp 3", ne);
    end
    // STEP held throughout RUN must not add reads
    ne = 0; div = 3; start = 1'b1; step = 1'b1;
    clk_step();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      clk_step();
      if (o_rom_en) ne++;
    end
    step = 1'b0;
    n_cmp++;
    if (ne !== 2) begin
      n_bad++; $display("FAIL step_in_run_count got %0d exp 2", ne);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL step_in_run_model got %h exp %h", obs, model_vec());
    end
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
    clk_step();
  endtask

  task automatic test_load_over_stop();
    load = 1'b1; load_addr = 8'h30; dir = 1'b1; div = 0;
    clk_step();
    load = 1'b0; start = 1'b1;
    clk_step();
    start = 1'b0;
    clk_step();
    clk_step();
    n_cmp++;
    if (o_rom_en !== 1'b1) begin
      n_bad++; $display("FAIL los_pre_en got %b exp 1", o_rom_en);
    end
    stop = 1'b1; load = 1'b1; load_addr = 8'h40;
    clk_step();
    stop = 1'b0; load = 1'b0;
    n_cmp++;
    if ({o_rom_addr, o_rom_en, o_valid, o_running} !== {8'h40, 1'b0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL los_after got %h exp %h", {o_rom_addr, o_rom_en, o_valid, o_running}, {8'h40, 3'b011});
    end
    clk_step();
    n_cmp++;
    if ({o_rom_addr, o_rom_en} !== {8'h40, 1'b1}) begin
      n_bad++; $display("FAIL los_issue got %h exp %h", {o_rom_addr, o_rom_en}, {8'h40, 1'b1});
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL los_model got %h exp %h", obs, model_vec());
    end
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
    clk_step();
  endtask

  task automatic test_div_drop_and_reset();
    div = 5; start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      clk_step();
      n_cmp++;
      if (o_rom_en !== 1'b0) begin
        n_bad++; $display("FAIL divdrop_pre c=%0d got %b exp 0", c, o_rom_en);
      end
    end
    div = 1;
    clk_step();
    n_cmp++;
    if (o_rom_en !== 1'b1) begin
      n_bad++; $display("FAIL divdrop_en got %b exp 1", o_rom_en);
    end
    rst_n = 1'b0;
    clk_step();
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_midread got %h exp 0", obs);
    end
    rst_n = 1'b1;
    clk_step();
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL reset_midread_model got %h exp %h", obs, model_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      step  = ($urandom_range(0, 5) == 0);
      load  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       load_addr = AW'($urandom_range(0, 2));
        1:       load_addr = AW'($urandom_range(MAXA - 2, MAXA));
        default: load_addr = AW'($urandom);
      endcase
      dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) div = DW'($urandom_range(0, 4));
      clk_step();
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++; $display("FAIL random i=%0d got %h exp %h", i, obs, model_vec());
      end
    end
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_div3();
    test_sequence(1'b0, "wrap_up", 8'hFE, 8'hFF, 8'h00, 8'h01);
    test_sequence(1'b1, "bounce", 8'hFE, 8'hFF, 8'hFE, 8'hFD);
    test_step();
    test_load_over_stop();
    test_div_drop_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_sequencer.md
# rom_sequencer

Read controller for the counter lookup ROM (CLK, EN, ADDR, 1-cycle registered DATA_OUT). It steps the ROM address at a programmable rate and supports run/stop, single-step, address load, and wrap or bounce sequencing. It raises VALID in the cycle the ROM's DATA_OUT presents the addressed word, so downstream display logic can capture it directly.

## Interface
- ADDR_BITS, 8, ROM address width; must match the ROM's address width.
- DIV_BITS, 24, prescaler width.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  level/pulse; enter RUN.
- STOP  in  1  enter IDLE.
- STEP  in  1  single read in IDLE.
- LOAD  in  1  load ROM_ADDR from LOAD_ADDR.
- LOAD_ADDR  in  ADDR_BITS  load value.
- DIR  in  1  1 = up, 0 = down; sampled on START and LOAD.
- MODE  in  1  0 = wrap, 1 = bounce; live.
- DIV  in  DIV_BITS  read period minus 1, in cycles; live.
- ROM_ADDR  out  ADDR_BITS  to ROM ADDR; registered.
- ROM_EN  out  1  to ROM EN; registered, one-cycle pulse per read.
- VALID  out  1  ROM DATA_OUT holds the word for the previous read.
- RUNNING  out  1  state == RUN.
- WRAP  out  1  one-cycle pulse on wrap or direction reversal.

## Operation
- States: IDLE, RUN. Reset sets IDLE, ROM_ADDR=0, ROM_EN=0, VALID=0, WRAP=0, PCNT=0, dir flag=up.
- Command priority per edge: LOAD > STOP > START > STEP. Lower commands are ignored in the same cycle.
- START (IDLE→RUN):
  - PCNT<=0; dir flag<=DIR.
  - START while in RUN is a no-op.
- STOP (RUN→IDLE):
  - No new reads are issued.
  - A ROM_EN already high still completes its address advance and VALID.
- RUN prescaler, per edge:
  - If PCNT >= DIV: PCNT<=0, ROM_EN<=1.
  - Else: PCNT<=PCNT+1, ROM_EN<=0.
  - The >= comparison makes a lowered DIV take effect immediately.
- STEP in IDLE: ROM_EN<=1 on the next edge, ignoring the prescaler. STEP in RUN is ignored.
- At every edge where ROM_EN==1: VALID<=1 and ROM_ADDR<=next(ROM_ADDR). Otherwise VALID<=0.
- next() in wrap mode (MODE=0):
  - Up: max→0. Down: 0→max. WRAP<=1 on either rollover.
- next() in bounce mode (MODE=1):
  - At max going up: next=max-1, dir flag flips, WRAP<=1.
  - At 0 going down: next=1, dir flag flips, WRAP<=1.
  - If the address is already at an end while moving outward, that end rule applies; there is no overshoot.
- LOAD:
  - ROM_ADDR<=LOAD_ADDR, dir flag<=DIR, PCNT<=0, ROM_EN<=0 (no new issue that cycle). State is unchanged.
  - If ROM_EN was high at that edge, LOAD overrides the advance. VALID still asserts, since the data is for the pre-load address.
- Address arithmetic is modulo 2^ADDR_BITS. No other limit registers.

## Timing
- ROM_ADDR is stable in every cycle ROM_EN is high. The ROM samples both at the next edge.
- VALID is high exactly one cycle after each ROM_EN cycle, aligned with the ROM's updated DATA_OUT. Read latency is 1 cycle.
- START sampled at edge e0: first ROM_EN high after edge e0+DIV+1, then every DIV+1 cycles.
- DIV=0: ROM_EN and VALID stay high continuously in RUN, and the address changes every cycle.
- WRAP is coincident with VALID for the read that triggered the rollover or reversal.
- RST_N low at any edge, mid-read included: all outputs take reset values on that edge. VALID is not produced for an interrupted read.

## Test plan
- Reset, then DIV=3, DIR=1, MODE=0, START pulse → ROM_EN high every 4th cycle; ROM_ADDR sequence 0,1,2,… at issue points; VALID one cycle after each ROM_EN.
- LOAD_ADDR=0xFE, DIV=0, wrap up → issued addresses FE, FF, 00, 01; WRAP pulse with the VALID for FF.
- MODE=1, LOAD 0xFE, DIR=1, DIV=0 → issued addresses FE, FF, FE, FD; RUNNING stays 1; one WRAP pulse with the VALID for FF.
- IDLE, ROM_ADDR=0x10, STEP pulses three times, spaced apart → three single ROM_EN pulses at 10, 11, 12; RUNNING stays 0. STEP while in RUN produces no extra reads.
- RUN with DIV=0 → STOP and LOAD=0x40 asserted on the same edge while ROM_EN=1 → LOAD wins: ROM_ADDR=0x40, VALID=1 next cycle, state stays RUN.
- RUN with DIV=5, PCNT=4 → drop DIV to 1 → ROM_EN on the next edge. Assert RST_N=0 in the cycle ROM_EN=1 → next cycle all outputs are 0.
